clock_lock_monitor: RTL and testbench

Single-clock checker for the display-controller clocking scheme. It consumes the PLL lock indication plus a divided toggle from a second, faster clock domain. It measures the toggle period in `clk` cycles and declares that clock good only after a run of in-window periods. Downstream logic gates the display path on `clk_ok` and reads `fault` / `fault_cnt` for diagnostics.

---
 rtl/clock_lock_monitor_pkg.sv | 19 +
 rtl/clock_lock_monitor_sync.sv | 29 ++
 rtl/clock_lock_monitor.sv | 151 +++++++++++++++
 tb/tb_clock_lock_monitor.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_lock_monitor_pkg.sv
// Shared definitions for clock checkers: monitor state encoding and
// default measurement window for the display-controller clocking scheme.
package clock_lock_monitor_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    MEASURE = 3'd2,
    LOCKED  = 3'd3,
    FAULT   = 3'd4
  } mon_state_t;

  // Nominal divided toggle period is 8 control-clock cycles.
  localparam int DEF_EXP_MIN   = 7;
  localparam int DEF_EXP_MAX   = 9;
  localparam int DEF_GOOD_NEED = 4;
  localparam int DEF_TIMEOUT   = 64;

endpackage

// File: rtl/clock_lock_monitor_sync.sv
// Two-flop synchronizer with a trailing register: exposes the synced level
// and a one-cycle pulse on either transition of that level.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic edge_pulse
);

  logic s1, s2, dly;

  // Metastability chain plus one delay stage for transition detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      dly <= 1'b0;
    end else begin
      s1  <= din;
      s2  <= s1;
      dly <= s2;
    end
  end

  assign level      = s2;
  assign edge_pulse = s2 ^ dly;

endmodule

// File: rtl/clock_lock_monitor.sv
// Measures the divided toggle period of a faster clock domain and declares
// that clock good after GOOD_NEED consecutive in-window periods.
module clock_lock_monitor
  import clock_lock_monitor_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int EXP_MIN   = DEF_EXP_MIN,
  parameter int EXP_MAX   = DEF_EXP_MAX,
  parameter int GOOD_NEED = DEF_GOOD_NEED,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_lock,
  input  logic             mon_toggle,
  input  logic             clr_fault,
  output logic             clk_ok,
  output logic             fault,
  output logic [CNT_W-1:0] last_period,
  output logic [7:0]       fault_cnt
);

  localparam logic [CNT_W-1:0] CNT_SAT = '1;
  localparam logic [CNT_W-1:0] WIN_LO  = CNT_W'(EXP_MIN);
  localparam logic [CNT_W-1:0] WIN_HI  = CNT_W'(EXP_MAX);
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
  localparam logic [3:0]       GOOD_LIM = 4'(GOOD_NEED);

  mon_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       good_cnt, good_nxt;
  logic             cnt_load;
  logic             lock_s, tgl_edge;
  logic             tgl_level, lock_edge;
  logic             in_win, timeout;

  sync_edge_det u_tgl_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (mon_toggle),
    .level      (tgl_level),
    .edge_pulse (tgl_edge)
  );

  sync_edge_det u_lock_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (pll_lock),
    .level      (lock_s),
    .edge_pulse (lock_edge)
  );

  // Toggle level and lock transitions are not needed; only edge and lock level are.
  logic unused_sync;
  assign unused_sync = tgl_level ^ lock_edge;

  // On an edge the counter still holds the distance since the previous edge.
  assign in_win  = (cnt >= WIN_LO) && (cnt <= WIN_HI);
  assign timeout = (cnt == TO_VAL);

  // State and good-run register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      good_cnt <= '0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_nxt;
    end
  end

  // Next-state: lock loss dominates; an edge beats a coincident timeout.
  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    cnt_load  = 1'b0;
    if (!lock_s) begin
      state_nxt = IDLE;
      good_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = ARM;
          good_nxt  = '0;
          cnt_load  = 1'b1;
        end
        ARM: begin
          // First period after arming has an unknown start point; skip judging it.
          if (tgl_edge) begin
            state_nxt = MEASURE;
            good_nxt  = '0;
          end else if (timeout) begin
            state_nxt = FAULT;
          end
        end
        MEASURE: begin
          if (tgl_edge) begin
            if (in_win) begin
              good_nxt = good_cnt + 4'd1;
              if (good_cnt + 4'd1 == GOOD_LIM) state_nxt = LOCKED;
            end else begin
              good_nxt = '0;
            end
          end else if (timeout) begin
            state_nxt = FAULT;
          end
        end
        LOCKED: begin
          if ((tgl_edge && !in_win) || (!tgl_edge && timeout)) state_nxt = FAULT;
        end
        FAULT: begin
          if (clr_fault) begin
            state_nxt = ARM;
            cnt_load  = 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          good_nxt  = '0;
        end
      endcase
    end
  end

  // Period counter: restarts at 1 on each edge, saturates, parked in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (cnt_load)         cnt <= CNT_W'(1);
    else if (state == IDLE)    cnt <= '0;
    else if (tgl_edge)         cnt <= CNT_W'(1);
    else if (cnt != CNT_SAT)   cnt <= cnt + CNT_W'(1);
  end

  // Capture each measured period while the monitor is actively tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_period <= '0;
    else if (tgl_edge && (state == ARM || state == MEASURE || state == LOCKED))
      last_period <= cnt;
  end

  // Saturating count of entries into FAULT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_cnt <= '0;
    else if (state_nxt == FAULT && state != FAULT && fault_cnt != 8'hFF)
      fault_cnt <= fault_cnt + 8'd1;
  end

  assign clk_ok = (state == LOCKED);
  assign fault  = (state == FAULT);

endmodule

// File: tb/tb_clock_lock_monitor.sv
// Self-checking bench: drives toggle periods and compares against a
// period-level reference model of the lock/fault rules.
module tb_clock_lock_monitor;

  localparam int EXP_MIN = 7, EXP_MAX = 9, GOOD_NEED = 4;

  logic       clk = 1'b0, rst_n = 1'b0, pll_lock = 1'b0, mon_toggle = 1'b0, clr_fault = 1'b0;
  logic       clk_ok, fault;
  logic [7:0] last_period, fault_cnt;

  clock_lock_monitor dut (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .mon_toggle(mon_toggle),
    .clr_fault(clr_fault), .clk_ok(clk_ok), .fault(fault),
    .last_period(last_period), .fault_cnt(fault_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0, errors = 0;

  // Reference model at the level of whole periods.
  localparam int M_IDLE = 0, M_ARM = 1, M_MEAS = 2, M_LOCK = 3, M_FLT = 4;
  int m_st = M_IDLE, m_run = 0, m_lp = 0, m_fcnt = 0, last_tgl = 0;
  bit m_lp_known = 1'b1;

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic bit good_period(input int p);
    return (p >= EXP_MIN) && (p <= EXP_MAX);
  endfunction

  task automatic model_fault();
    m_st = M_FLT;
    if (m_fcnt < 255) m_fcnt++;
  endtask

  task automatic model_edge(input int p);
    case (m_st)
      M_ARM:  begin m_st = M_MEAS; m_run = 0; m_lp_known = 1'b0; end
      M_MEAS: begin
        m_lp = p; m_lp_known = 1'b1;
        if (good_period(p)) begin
          m_run++;
          if (m_run == GOOD_NEED) m_st = M_LOCK;
        end else m_run = 0;
      end
      M_LOCK: begin
        m_lp = p; m_lp_known = 1'b1;
        if (!good_period(p)) model_fault();
      end
      default: ;
    endcase
  endtask

  // Flip the toggle, let the edge propagate (5 cycles), then update the model.
  task automatic pulse_toggle();
    int p;
    p = cyc - last_tgl;
    last_tgl = cyc;
    mon_toggle = ~mon_toggle;
    tick(5);
    model_edge(p);
  endtask

  task automatic bring_up();
    rst_n = 1'b0; pll_lock = 1'b0; mon_toggle = 1'b0; clr_fault = 1'b0;
    tick(2);
    rst_n = 1'b1; pll_lock = 1'b1;
    tick(6);
    m_st = M_ARM; m_run = 0; m_lp = 0; m_lp_known = 1'b1; m_fcnt = 0; last_tgl = cyc;
  endtask

  task automatic test_reset();
    tick(2);
    vectors += 4;
    if (clk_ok !== 1'b0) begin errors++; $display("FAIL reset clk_ok got %0b want 0", clk_ok); end
    if (fault !== 1'b0) begin errors++; $display("FAIL reset fault got %0b want 0", fault); end
    if (last_period !== 8'd0) begin errors++; $display("FAIL reset last_period got %0d want 0", last_period); end
    if (fault_cnt !== 8'd0) begin errors++; $display("FAIL reset fault_cnt got %0d want 0", fault_cnt); end
  endtask

  task automatic test_nominal();
    bring_up();
    for (int i = 0; i < 6; i++) begin
      pulse_toggle();
      vectors += 3;
      if (clk_ok !== (m_st == M_LOCK)) begin errors++; $display("FAIL nominal[%0d] clk_ok got %0b want %0b", i, clk_ok, m_st == M_LOCK); end
      if (fault !== 1'b0) begin errors++; $display("FAIL nominal[%0d] fault got %0b want 0", i, fault); end
      if (m_lp_known) begin
        vectors++;
        if (last_period !== 8'(m_lp)) begin errors++; $display("FAIL nominal[%0d] last_period got %0d want %0d", i, last_period, m_lp); end
      end
      tick(3);
    end
    vectors += 2;
    if (clk_ok !== 1'b1) begin errors++; $display("FAIL nominal_locked clk_ok got %0b want 1", clk_ok); end
    if (last_period !== 8'd8) begin errors++; $display("FAIL nominal_period last_period got %0d want 8", last_period); end
  endtask

  task automatic test_out_of_window();
    int gaps[7] = '{8, 8, 12, 8, 8, 8, 8};
    bring_up();
    pulse_toggle();
    for (int i = 0; i < 7; i++) begin
      tick(gaps[i] - 5);
      pulse_toggle();
      vectors += 3;
      if (clk_ok !== (m_st == M_LOCK)) begin errors++; $display("FAIL oow[%0d] clk_ok got %0b want %0b", i, clk_ok, m_st == M_LOCK); end
      if (last_period !== 8'(m_lp)) begin errors++; $display("FAIL oow[%0d] last_period got %0d want %0d", i, last_period, m_lp); end
      if (fault_cnt !== 8'd0) begin errors++; $display("FAIL oow[%0d] fault_cnt got %0d want 0", i, fault_cnt); end
    end
    vectors++;
    if (clk_ok !== 1'b1) begin errors++; $display("FAIL oow_final clk_ok got %0b want 1", clk_ok); end
  endtask

  // Enters with the monitor locked, 5 cycles after the last toggle.
  task automatic test_dead_clock();
    tick(55);
    vectors++;
    if (fault !== 1'b0) begin errors++; $display("FAIL dead_early fault got %0b want 0", fault); end
    tick(10);
    model_fault();
    vectors += 3;
    if (fault !== 1'b1) begin errors++; $display("FAIL dead fault got %0b want 1", fault); end
    if (clk_ok !== 1'b0) begin errors++; $display("FAIL dead clk_ok got %0b want 0", clk_ok); end
    if (fault_cnt !== 8'(m_fcnt)) begin errors++; $display("FAIL dead fault_cnt got %0d want %0d", fault_cnt, m_fcnt); end
  endtask

  task automatic test_recovery();
    pulse_toggle(); tick(3);
    pulse_toggle(); tick(1);
    clr_fault = 1'b1; tick(1); clr_fault = 1'b0; m_st = M_ARM; m_run = 0;
    tick(1);
    for (int i = 0; i < 5; i++) begin
      pulse_toggle();
      vectors += 2;
      if (clk_ok !== (m_st == M_LOCK)) begin errors++; $display("FAIL recover[%0d] clk_ok got %0b want %0b", i, clk_ok, m_st == M_LOCK); end
      if (fault !== 1'b0) begin errors++; $display("FAIL recover[%0d] fault got %0b want 0", i, fault); end
      tick(3);
    end
    vectors++;
    if (clk_ok !== 1'b1) begin errors++; $display("FAIL recover_locked clk_ok got %0b want 1", clk_ok); end
    // Freeze again, then clear in the very cycle the synced lock drops.
    tick(62);
    model_fault();
    pll_lock = 1'b0;
    tick(2);
    vectors++;
    if (fault !== 1'b1) begin errors++; $display("FAIL clr_lock_pre fault got %0b want 1", fault); end
    clr_fault = 1'b1; tick(1); clr_fault = 1'b0;
    m_st = M_IDLE;
    vectors += 2;
    if (fault !== 1'b0) begin errors++; $display("FAIL clr_lock fault got %0b want 0", fault); end
    if (fault_cnt !== 8'(m_fcnt)) begin errors++; $display("FAIL clr_lock fault_cnt got %0d want %0d", fault_cnt, m_fcnt); end
  endtask

  task automatic test_lock_loss();
    pll_lock = 1'b1;
    tick(6);
    m_st = M_ARM; m_run = 0; last_tgl = cyc;
    for (int i = 0; i < 6; i++) begin pulse_toggle(); tick(3); end
    vectors++;
    if (clk_ok !== 1'b1) begin errors++; $display("FAIL lockloss_pre clk_ok got %0b want 1", clk_ok); end
    pll_lock = 1'b0;
    tick(2);
    vectors++;
    if (clk_ok !== 1'b1) begin errors++; $display("FAIL lockloss_2cyc clk_ok got %0b want 1", clk_ok); end
    tick(1);
    vectors += 3;
    if (clk_ok !== 1'b0) begin errors++; $display("FAIL lockloss clk_ok got %0b want 0", clk_ok); end
    if (fault !== 1'b0) begin errors++; $display("FAIL lockloss fault got %0b want 0", fault); end
    if (fault_cnt !== 8'(m_fcnt)) begin errors++; $display("FAIL lockloss fault_cnt got %0d want %0d", fault_cnt, m_fcnt); end
  endtask

  task automatic test_async_reset();
    bring_up();
    for (int i = 0; i < 6; i++) begin pulse_toggle(); tick(3); end
    tick(1);
    #1 rst_n = 1'b0;
    #1;
    vectors += 4;
    if (clk_ok !== 1'b0) begin errors++; $display("FAIL areset clk_ok got %0b want 0", clk_ok); end
    if (fault !== 1'b0) begin errors++; $display("FAIL areset fault got %0b want 0", fault); end
    if (last_period !== 8'd0) begin errors++; $display("FAIL areset last_period got %0d want 0", last_period); end
    if (fault_cnt !== 8'd0) begin errors++; $display("FAIL areset fault_cnt got %0d want 0", fault_cnt); end
    tick(1);
  endtask

  task automatic test_random();
    int g;
    bring_up();
    for (int i = 0; i < 80; i++) begin
      pulse_toggle();
      vectors += 3;
      if (clk_ok !== (m_st == M_LOCK)) begin errors++; $display("FAIL rand[%0d] clk_ok got %0b want %0b", i, clk_ok, m_st == M_LOCK); end
      if (fault !== (m_st == M_FLT)) begin errors++; $display("FAIL rand[%0d] fault got %0b want %0b", i, fault, m_st == M_FLT); end
      if (fault_cnt !== 8'(m_fcnt)) begin errors++; $display("FAIL rand[%0d] fault_cnt got %0d want %0d", i, fault_cnt, m_fcnt); end
      if (m_lp_known) begin
        vectors++;
        if (last_period !== 8'(m_lp)) begin errors++; $display("FAIL rand[%0d] last_period got %0d want %0d", i, last_period, m_lp); end
      end
      g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 12)) : int'($urandom_range(7, 9));
      if (m_st == M_FLT && g >= 7 && $urandom_range(0, 1) == 1) begin
        tick(1); clr_fault = 1'b1; tick(1); clr_fault = 1'b0;
        m_st = M_ARM; m_run = 0;
        tick(g - 7);
      end else begin
        tick(g - 5);
      end
    end
  endtask

  // ARM with a frozen toggle times out; clear and repeat past saturation.
  task automatic test_saturation();
    bring_up();
    for (int i = 0; i < 260; i++) begin
      tick(70);
      model_fault();
      if (i == 0 || i == 99 || i == 254 || i == 259) begin
        vectors += 2;
        if (fault !== 1'b1) begin errors++; $display("FAIL sat[%0d] fault got %0b want 1", i, fault); end
        if (fault_cnt !== 8'(m_fcnt)) begin errors++; $display("FAIL sat[%0d] fault_cnt got %0d want %0d", i, fault_cnt, m_fcnt); end
      end
      clr_fault = 1'b1; tick(1); clr_fault = 1'b0;
      m_st = M_ARM;
    end
    vectors++;
    if (fault_cnt !== 8'd255) begin errors++; $display("FAIL sat_final fault_cnt got %0d want 255", fault_cnt); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_out_of_window();
    test_dead_clock();
    test_recovery();
    test_lock_loss();
    test_async_reset();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
